div_s_iter: RTL

DIV_S_ITER -- requirements
Module: div_s_iter

---
 rtl/div_s_iter_pkg.sv | 23 ++
 rtl/div_s_iter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/div_s_iter_pkg.sv
// Shared fixed-point definitions for the basic-op blocks: FSM states, Q15 constants,
// operand classification and the default iteration count.
package div_s_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NORM = 2'd0,
    OP_EQ   = 2'd1,
    OP_ZERO = 2'd2,
    OP_ERR  = 2'd3
  } opclass_e;

  localparam logic signed [15:0] MAX_16  = 16'sh7FFF;
  localparam logic signed [15:0] ZERO_16 = 16'sh0000;

  localparam int unsigned ITER_DEFAULT = 15;

endpackage

// File: rtl/div_s_iter.sv
// Iterative Q15 fractional divider (restoring shift/subtract, one quotient bit per cycle)
// with fixed latency for every operand case, including special and error operands.
module div_s_iter
  import div_s_iter_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] num,
  input  logic signed [15:0] den,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] quo,
  output logic               err
);

  localparam int unsigned CW = (ITER < 2) ? 1 : $clog2(ITER + 1);

  state_e             state_q, state_d;
  opclass_e           opc_q,   opc_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [31:0]        rem_q,   rem_d;
  logic [31:0]        div_q,   div_d;
  logic [15:0]        qacc_q,  qacc_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic signed [15:0] quo_q,   quo_d;
  logic               err_q,   err_d;
  logic [31:0]        rem_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opc_q   <= OP_NORM;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      qacc_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= ZERO_16;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      qacc_q  <= qacc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    qacc_d  = qacc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    err_d   = err_q;
    rem_sh  = rem_q << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          rem_d   = {16'b0, num};
          div_d   = {16'b0, den};
          qacc_d  = '0;
          busy_d  = 1'b1;
          // Special cases are classified here; the datapath still runs all
          // iterations so every operand pair sees the same latency.
          if (num[15] || den[15] || (den == ZERO_16) || (num > den))
            opc_d = OP_ERR;
          else if (num == den)
            opc_d = OP_EQ;
          else if (num == ZERO_16)
            opc_d = OP_ZERO;
          else
            opc_d = OP_NORM;
        end
      end

      RUN: begin
        if (cnt_q == CW'(ITER)) begin
          state_d = DONE;
          done_d  = 1'b1;
          case (opc_q)
            OP_ERR:  begin quo_d = ZERO_16;          err_d = 1'b1; end
            OP_EQ:   begin quo_d = MAX_16;           err_d = 1'b0; end
            OP_ZERO: begin quo_d = ZERO_16;          err_d = 1'b0; end
            default: begin quo_d = $signed(qacc_q);  err_d = 1'b0; end
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (rem_sh >= div_q) begin
            rem_d  = rem_sh - div_q;
            qacc_d = {qacc_q[14:0], 1'b1};
          end else begin
            rem_d  = rem_sh;
            qacc_d = {qacc_q[14:0], 1'b0};
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;
  assign err  = err_q;

endmodule
